// File: rtl/mips_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_rf_pkg
// Purpose  : Shared constants and types for the register-file dump sequencer:
//            default widths, FSM state encoding and the output beat record.
// Revision : 1.0 - initial release
// ============================================================================
package mips_rf_pkg;

    // Default register file geometry
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    // Dumper FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    // One output beat: register number, its contents, end-of-range flag
    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] regnum;
        logic [RF_DATA_WIDTH-1:0] data;
        logic                     last;
    } beat_t;

endpackage : mips_rf_pkg
`default_nettype wire

// File: rtl/mips_rf_dumper.sv
`default_nettype none
// ============================================================================
// Module   : mips_rf_dumper
// Purpose  : Walks an inclusive register range through one combinational
//            regfile read port and streams each register out as a
//            valid/ready beat tagged with its register number.
// Revision : 1.0 - initial release
// ============================================================================
module mips_rf_dumper
    import mips_rf_pkg::*;
#(
    parameter int DATA_WIDTH = mips_rf_pkg::RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = mips_rf_pkg::RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,       // asynchronous, active-low
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_reg,
    input  logic [ADDR_WIDTH-1:0] last_reg,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rd_regnum,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_regnum,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] idx;         // register currently being fetched/sent
    logic [ADDR_WIDTH-1:0] end_idx;     // last register of the range, inclusive
    logic [ADDR_WIDTH-1:0] idx_inc;
    logic                  fire;
    logic                  range_ok;

    // Handshake, bypassed read address and status decoded from current state
    always_comb begin
        fire     = out_valid & out_ready;
        idx_inc  = idx + 1'b1;
        range_ok = (first_reg <= last_reg);
        busy     = (state != ST_IDLE);
        // On an accepted non-final beat the next register is read this same
        // cycle so the replacement beat is captured on the accepting edge.
        if ((state == ST_SEND) && fire && !out_last) begin
            rd_regnum = idx_inc;
        end else begin
            rd_regnum = idx;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort wins over everything once a dump is running
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start && range_ok) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (fire && out_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Range pointers, output beat register and done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            end_idx    <= '0;
            out_valid  <= 1'b0;
            out_regnum <= '0;
            out_data   <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (range_ok) begin
                            idx     <= first_reg;
                            end_idx <= last_reg;
                        end else begin
                            // Empty range: nothing to send, finish at once
                            done <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                    end else begin
                        out_data   <= rd_data;
                        out_regnum <= idx;
                        out_last   <= (idx == end_idx);
                        out_valid  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        // In-flight beat is dropped even if it fires now
                        out_valid <= 1'b0;
                    end else if (fire) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx        <= idx_inc;
                            out_data   <= rd_data;
                            out_regnum <= idx_inc;
                            out_last   <= (idx_inc == end_idx);
                        end
                    end
                    // Without fire the held beat stays untouched
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : mips_rf_dumper
`default_nettype wire

// File: tb/tb_mips_rf_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_rf_dumper
// Purpose  : Self-checking bench for mips_rf_dumper with a behavioural
//            register file (r0 hardwired to zero, combinational read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_rf_dumper;
    import mips_rf_pkg::*;

    localparam int AW = RF_ADDR_WIDTH;
    localparam int DW = RF_DATA_WIDTH;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] first_reg;
    logic [AW-1:0] last_reg;
    logic          abort;
    logic [AW-1:0] rd_regnum;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_regnum;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [0:31];

    int checks   = 0;
    int failures = 0;

    // Regfile read port model
    assign rd_data = (rd_regnum == '0) ? '0 : regs[rd_regnum];

    mips_rf_dumper #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_reg  (first_reg),
        .last_reg   (last_reg),
        .abort      (abort),
        .rd_regnum  (rd_regnum),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_regnum (out_regnum),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic [AW-1:0] first_reg;
        logic [AW-1:0] last_reg;
        logic          abort;
        logic          ready;
        logic          exp_valid;
        beat_t         exp_beat;
        logic          exp_done;
        logic          exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input int f, input int l,
                                input logic a, input logic r, input logic v,
                                input int rn, input int d, input logic lst,
                                input logic dn, input logic b);
        vec_t t;
        t.start           = s;
        t.first_reg       = AW'(f);
        t.last_reg        = AW'(l);
        t.abort           = a;
        t.ready           = r;
        t.exp_valid       = v;
        t.exp_beat.regnum = AW'(rn);
        t.exp_beat.data   = DW'(d);
        t.exp_beat.last   = lst;
        t.exp_done        = dn;
        t.exp_busy        = b;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        first_reg = '0;
        last_reg  = '0;
        abort     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int beats;
        int cyc;

        reset     = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        for (int i = 0; i < 32; i++) regs[i] = DW'(i * 3);
        regs[1] = 32'd15;
        regs[2] = 32'd88;

        step();
        step();
        check("reset valid",  {31'd0, out_valid}, 32'd0);
        check("reset regnum", {27'd0, out_regnum}, 32'd0);
        check("reset data",   out_data, 32'd0);
        check("reset last",   {31'd0, out_last}, 32'd0);
        check("reset done",   {31'd0, done}, 32'd0);
        check("reset busy",   {31'd0, busy}, 32'd0);
        reset = 1'b1;
        step();

        //          s  f  l  a  r   v  rn  d   lst dn b
        vecs.push_back(mk(1, 1, 2, 0, 1,  0, 0, 0,  0, 0, 1)); // start 1..2
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 1, 15, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 2, 88, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 7, 3, 0, 1,  0, 0, 0,  0, 1, 0)); // empty range
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 4, 6, 0, 1,  0, 0, 0,  0, 0, 1)); // backpressure 4..6
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 4, 12, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 5, 15, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0,  1, 5, 15, 0, 0, 1)); // start while busy
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 5, 15, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 6, 18, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 6, 18, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1,  0, 0, 0,  0, 0, 0)); // abort in IDLE
        vecs.push_back(mk(1, 9, 9, 0, 0,  0, 0, 0,  0, 0, 1)); // single 9..9
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 9, 27, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 10, 12, 0, 1, 0, 0, 0, 0, 0, 1)); // abort in FETCH
        vecs.push_back(mk(0, 0, 0, 1, 1,  0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            start     = vecs[i].start;
            first_reg = vecs[i].first_reg;
            last_reg  = vecs[i].last_reg;
            abort     = vecs[i].abort;
            out_ready = vecs[i].ready;
            step();
            check($sformatf("vec%0d valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d done", i),  {31'd0, done},      {31'd0, vecs[i].exp_done});
            check($sformatf("vec%0d busy", i),  {31'd0, busy},      {31'd0, vecs[i].exp_busy});
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d regnum", i), {27'd0, out_regnum}, {27'd0, vecs[i].exp_beat.regnum});
                check($sformatf("vec%0d data", i),   out_data, vecs[i].exp_beat.data);
                check($sformatf("vec%0d last", i),   {31'd0, out_last}, {31'd0, vecs[i].exp_beat.last});
            end
        end
        idle_inputs();

        // Full-depth dump 0..31 with rN = 3N
        regs[1] = 32'd3;
        regs[2] = 32'd6;
        start = 1'b1; first_reg = 5'd0; last_reg = 5'd31; out_ready = 1'b1;
        step();
        idle_inputs();
        cyc = 1;
        beats = 0;
        while (beats < 32 && cyc < 60) begin
            if (out_valid) begin
                check($sformatf("full regnum %0d", beats), {27'd0, out_regnum}, beats);
                check($sformatf("full data %0d", beats), out_data, beats * 3);
                check($sformatf("full last %0d", beats), {31'd0, out_last}, (beats == 31) ? 1 : 0);
                if (beats == 31) check("full last-beat cycle", cyc, 33);
                beats++;
            end
            step();
            cyc++;
        end
        check("full beat count", beats, 32);
        check("full done", {31'd0, done}, 32'd1);
        check("full valid off", {31'd0, out_valid}, 32'd0);
        step();
        check("full done one cycle", {31'd0, done}, 32'd0);

        // Abort at beat 5 of a 0..31 dump, then a fresh 9..9 dump
        start = 1'b1; first_reg = 5'd0; last_reg = 5'd31; out_ready = 1'b1;
        step();
        idle_inputs();
        n = 0;
        while (!(out_valid && out_regnum == 5'd5) && n < 20) begin
            step();
            n++;
        end
        check("abort reached beat5", {27'd0, out_regnum}, 32'd5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort valid", {31'd0, out_valid}, 32'd0);
        check("abort done",  {31'd0, done}, 32'd0);
        check("abort busy",  {31'd0, busy}, 32'd0);
        step();
        check("abort no late done", {31'd0, done}, 32'd0);
        start = 1'b1; first_reg = 5'd9; last_reg = 5'd9;
        step();
        idle_inputs();
        step();
        check("post-abort valid",  {31'd0, out_valid}, 32'd1);
        check("post-abort regnum", {27'd0, out_regnum}, 32'd9);
        check("post-abort data",   out_data, 32'd27);
        check("post-abort last",   {31'd0, out_last}, 32'd1);
        step();
        check("post-abort done",   {31'd0, done}, 32'd1);

        // Reset asserted mid-dump clears outputs without waiting for an edge
        start = 1'b1; first_reg = 5'd4; last_reg = 5'd31; out_ready = 1'b0;
        step();
        idle_inputs();
        step();
        check("pre-reset data", out_data, 32'd12);
        #2;
        reset = 1'b0;
        #1;
        check("async reset valid",  {31'd0, out_valid}, 32'd0);
        check("async reset regnum", {27'd0, out_regnum}, 32'd0);
        check("async reset data",   out_data, 32'd0);
        check("async reset last",   {31'd0, out_last}, 32'd0);
        check("async reset busy",   {31'd0, busy}, 32'd0);
        check("async reset rdnum",  {27'd0, rd_regnum}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("after reset done %0d", i),  {31'd0, done}, 32'd0);
            check($sformatf("after reset valid %0d", i), {31'd0, out_valid}, 32'd0);
        end

        // Write to r3 before capture is seen; write after capture is not
        start = 1'b1; first_reg = 5'd0; last_reg = 5'd5; out_ready = 1'b0;
        step();
        idle_inputs();
        step();
        check("wr beat0 regnum", {27'd0, out_regnum}, 32'd0);
        regs[3] = 32'hDEAD;
        out_ready = 1'b1;
        step();
        step();
        step();
        check("wr r3 regnum", {27'd0, out_regnum}, 32'd3);
        check("wr r3 data", out_data, 32'hDEAD);
        out_ready = 1'b0;
        regs[3] = 32'hBEEF;
        step();
        check("wr r3 held data", out_data, 32'hDEAD);
        out_ready = 1'b1;
        step();
        check("wr r4 data", out_data, 32'd12);
        step();
        check("wr r5 data", out_data, 32'd15);
        check("wr r5 last", {31'd0, out_last}, 32'd1);
        step();
        check("wr done", {31'd0, done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mips_rf_dumper
`default_nettype wire

// File: doc/mips_rf_dumper.md
Name: mips_rf_dumper

Overview:
Read-side sequencer for mips_regfile. It drives one regfile read port and walks a register range. Each register's contents go out as a valid/ready stream beat tagged with its register number. Used by the lab debug/trace path to snapshot architectural state after a test program, the counterpart to the write port driven by the datapath.

Parameters:
DATA_WIDTH, 32, width of a register and of out_data
ADDR_WIDTH, 5, register number width; regfile depth is 2**ADDR_WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low (0 = reset)
start  input  1  one-cycle request to begin a dump; honoured only in IDLE
first_reg  input  ADDR_WIDTH  first register of range; sampled with start
last_reg  input  ADDR_WIDTH  last register of range, inclusive; sampled with start
abort  input  1  synchronous cancel of a dump in progress
rd_regnum  output  ADDR_WIDTH  to regfile read port register select
rd_data  input  DATA_WIDTH  from regfile read port; combinational function of rd_regnum
out_valid  output  1  beat available
out_ready  input  1  consumer accepts beat
out_regnum  output  ADDR_WIDTH  register number of current beat
out_data  output  DATA_WIDTH  register contents of current beat
out_last  output  1  current beat is last_reg
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after last beat accepted, or after an empty range

Behaviour:
- States: IDLE, FETCH, SEND. All state and output registers use the async active-low reset.
- Reset values: state=IDLE, idx=0, end_idx=0, out_valid=0, out_regnum=0, out_data=0, out_last=0, done=0, busy=0.
- rd_regnum is combinational:
  - idx+1 when state==SEND and fire and !out_last;
  - otherwise idx.
  - fire = out_valid & out_ready.
- IDLE, start=1, first_reg<=last_reg: latch idx<=first_reg and end_idx<=last_reg; go to FETCH.
- IDLE, start=1, first_reg>last_reg: empty range; no beats; done=1 next cycle; stay IDLE.
- FETCH, one cycle:
  - capture out_data<=rd_data, out_regnum<=idx, out_last<=(idx==end_idx);
  - out_valid<=1; go to SEND.
  - The first beat is therefore visible 2 cycles after start.
- SEND:
  - While !out_ready, hold out_valid, out_regnum, out_data and out_last stable.
  - On fire with !out_last: in the same edge idx<=idx+1, capture rd_data for idx+1 (via the rd_regnum bypass), out_regnum<=idx+1, out_last<=(idx+1==end_idx). out_valid stays 1.
  - Throughput is one beat per cycle under continuous out_ready.
  - On fire with out_last: out_valid<=0, done<=1 for one cycle, go to IDLE.
- No wrap-around: idx never passes end_idx. Range 0..31 is full depth and yields 32 beats. first_reg==last_reg yields exactly one beat with out_last=1.
- out_data is sampled at capture time. A regfile write to a register before its capture is seen; a write after its capture is not. A beat already held in SEND is never refreshed.
- abort (highest priority in FETCH/SEND): next edge goes to IDLE with out_valid=0 and done=0. The in-flight beat is dropped, even if fire occurs in the same cycle. abort in IDLE has no effect.
- start while busy is ignored; first_reg/last_reg changes during a dump are ignored.
- Reset asserted mid-dump: immediate return to reset values; no done pulse.
- Register 0 is dumped like any other; it reads 0 from the regfile.

Decomposition:
- Shared package mips_rf_pkg: ADDR_WIDTH/DATA_WIDTH constants, a state enum (IDLE, FETCH, SEND), and a beat struct {regnum, data, last}.
- No sub-module needed. The FSM and output register live in one module; the bench instantiates mips_regfile alongside it.

Test Plan:
- Preload r2=88, r1=15; start with first=1, last=2, out_ready=1 -> beats (1,15,last=0), (2,88,last=1) on consecutive cycles, first beat 2 cycles after start; done pulses one cycle after the second beat.
- Full dump 0..31 after writing rN=N*3, out_ready=1 -> 32 beats, r0=0, r31=93, out_last only on 31, 33 cycles from start to last beat.
- Backpressure: range 4..6, out_ready toggling 1,0,0,1,0,1 -> each beat held stable while out_ready=0, data values 12,15,18 in order, no beat duplicated or lost.
- Empty range first=7, last=3 -> no out_valid; done=1 exactly one cycle after start; busy stays 0.
- abort during SEND of a 0..31 dump at beat 5 -> out_valid drops next cycle, no done, busy=0; a new start for 9..9 then yields one beat (9,27,last=1).
- Reset pulled low mid-dump, and regfile write r3=0xDEAD during a dump before r3 is captured -> reset clears all outputs immediately; a separate run shows out_data=0xDEAD for r3.
